// File: rtl/posit_div_seq.sv
// Sequential posit divider core: restoring mantissa divide (one quotient bit per cycle)
// with scale/regime arithmetic and NaR/zero fast path, valid/ready on both sides.
module posit_div_seq #(
    parameter int N  = 8,
    parameter int ES = 4,
    parameter int RS = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              Sign1,
    input  logic              Sign2,
    input  logic [RS:0]       k1,
    input  logic [RS:0]       k2,
    input  logic [ES-1:0]     Exponent1,
    input  logic [ES-1:0]     Exponent2,
    input  logic [N-1:0]      Mantissa1,
    input  logic [N-1:0]      Mantissa2,
    input  logic              inf1,
    input  logic              inf2,
    input  logic              zero1,
    input  logic              zero2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [2*N-1:0]    Div_Mant_N,
    output logic [RS+ES+4:0]  Total_EO,
    output logic [ES-1:0]     E_O,
    output logic [RS+4:0]     R_O,
    output logic [RS+4:0]     sumR,
    output logic              inf,
    output logic              zero,
    output logic              Sign
);
    localparam int TW  = RS + ES + 5;
    localparam int RW  = RS + 5;
    localparam int SEW = ES + 3;
    localparam int QW  = 2 * N + 1;
    localparam int CW  = $clog2(2 * N + 1);
    localparam int SCW = TW + ES + 2 * RW;
    localparam logic [CW-1:0] CNT_INIT = CW'(2 * N);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // Packs {Total_EO, E_O, R_O, sumR}; uf=1 means the quotient needed a one-bit renormalisation.
    function automatic logic [SCW-1:0] scale_f(input logic [ES-1:0] e1, input logic [ES-1:0] e2,
                                               input logic [RS:0] ka, input logic [RS:0] kb,
                                               input logic uf);
        logic [SEW-1:0] se;
        logic [RW-1:0]  sr;
        logic [TW-1:0]  tot;
        logic [TW-1:0]  t;
        logic [RW-1:0]  ro;
        se  = {3'b000, e1} - {3'b000, e2} - {{(SEW-1){1'b0}}, uf};
        sr  = {{(RW-RS-1){ka[RS]}}, ka} - {{(RW-RS-1){kb[RS]}}, kb};
        tot = ({{(TW-RW){sr[RW-1]}}, sr} << ES) + {{(TW-SEW){se[SEW-1]}}, se};
        t   = tot[TW-1] ? (~tot + {{(TW-1){1'b0}}, 1'b1}) : tot;
        if (!tot[TW-1] || (t[ES-1:0] != {ES{1'b0}})) begin
            ro = t[TW-1:ES] + {{(RW-1){1'b0}}, 1'b1};
        end else begin
            ro = t[TW-1:ES];
        end
        return {tot, tot[ES-1:0], ro, sr};
    endfunction

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N:0]     rem_q, rem_d;
    logic [2*N-1:0] q_q, q_d;
    logic [N-1:0]   m2_q, m2_d;
    logic [ES-1:0]  e1_q, e1_d, e2_q, e2_d;
    logic [RS:0]    k1_q, k1_d, k2_q, k2_d;
    logic           sign_q, sign_d;
    logic [2*N-1:0] mant_q, mant_d;
    logic [TW-1:0]  tot_q, tot_d;
    logic [ES-1:0]  eo_q, eo_d;
    logic [RW-1:0]  ro_q, ro_d, sr_q, sr_d;
    logic           inf_q, inf_d, zero_q, zero_d, sgno_q, sgno_d;

    logic           ge_s, sticky_s, nar_s;
    logic [N:0]     rem_nx_s;
    logic [QW-1:0]  q_nx_s;
    logic [SCW-1:0] sc_s;

    assign ge_s     = (rem_q >= {1'b0, m2_q});
    assign rem_nx_s = ge_s ? (rem_q - {1'b0, m2_q}) : rem_q;
    assign q_nx_s   = {q_q, ge_s};
    assign sticky_s = (rem_nx_s != {(N+1){1'b0}});
    assign nar_s    = inf1 | inf2 | zero2;
    assign sc_s     = (state_q == S_IDLE) ? scale_f(Exponent1, Exponent2, k1, k2, 1'b0)
                                          : scale_f(e1_q, e2_q, k1_q, k2_q, ~q_nx_s[QW-1]);

    // Next-state and datapath control for the IDLE/DIVIDE/DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        q_d     = q_q;
        m2_d    = m2_q;
        e1_d    = e1_q;
        e2_d    = e2_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        sign_d  = sign_q;
        mant_d  = mant_q;
        tot_d   = tot_q;
        eo_d    = eo_q;
        ro_d    = ro_q;
        sr_d    = sr_q;
        inf_d   = inf_q;
        zero_d  = zero_q;
        sgno_d  = sgno_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    e1_d   = Exponent1;
                    e2_d   = Exponent2;
                    k1_d   = k1;
                    k2_d   = k2;
                    m2_d   = Mantissa2;
                    sign_d = Sign1 ^ Sign2;
                    rem_d  = {1'b0, Mantissa1};
                    q_d    = {(2*N){1'b0}};
                    cnt_d  = CNT_INIT;
                    if (nar_s || zero1) begin
                        mant_d  = {(2*N){1'b0}};
                        {tot_d, eo_d, ro_d, sr_d} = sc_s;
                        inf_d   = nar_s;
                        zero_d  = zero1 & ~nar_s;
                        sgno_d  = Sign1 ^ Sign2;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIVIDE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIVIDE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    if (q_nx_s[QW-1]) begin
                        mant_d = {q_nx_s[QW-1:2], q_nx_s[1] | q_nx_s[0] | sticky_s};
                    end else begin
                        mant_d = {q_nx_s[QW-2:1], q_nx_s[0] | sticky_s};
                    end
                    {tot_d, eo_d, ro_d, sr_d} = sc_s;
                    inf_d   = 1'b0;
                    zero_d  = 1'b0;
                    sgno_d  = sign_q;
                    state_d = S_DONE;
                end else begin
                    // Partial remainder stays below M2, so the doubled value fits N+1 bits.
                    rem_d = {rem_nx_s[N-1:0], 1'b0};
                    q_d   = q_nx_s[QW-2:0];
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset clears everything and aborts any division.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CW{1'b0}};
            rem_q   <= {(N+1){1'b0}};
            q_q     <= {(2*N){1'b0}};
            m2_q    <= {N{1'b0}};
            e1_q    <= {ES{1'b0}};
            e2_q    <= {ES{1'b0}};
            k1_q    <= {(RS+1){1'b0}};
            k2_q    <= {(RS+1){1'b0}};
            sign_q  <= 1'b0;
            mant_q  <= {(2*N){1'b0}};
            tot_q   <= {TW{1'b0}};
            eo_q    <= {ES{1'b0}};
            ro_q    <= {RW{1'b0}};
            sr_q    <= {RW{1'b0}};
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
            sgno_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            m2_q    <= m2_d;
            e1_q    <= e1_d;
            e2_q    <= e2_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            sign_q  <= sign_d;
            mant_q  <= mant_d;
            tot_q   <= tot_d;
            eo_q    <= eo_d;
            ro_q    <= ro_d;
            sr_q    <= sr_d;
            inf_q   <= inf_d;
            zero_q  <= zero_d;
            sgno_q  <= sgno_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q == S_DIVIDE);
    assign out_valid  = (state_q == S_DONE);
    assign Div_Mant_N = mant_q;
    assign Total_EO   = tot_q;
    assign E_O        = eo_q;
    assign R_O        = ro_q;
    assign sumR       = sr_q;
    assign inf        = inf_q;
    assign zero       = zero_q;
    assign Sign       = sgno_q;
endmodule

// File: tb/tb_posit_div_seq.sv
// Directed self-checking bench for posit_div_seq (N=8, ES=4) with hand-computed results.
module tb_posit_div_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic        Sign1, Sign2, inf1, inf2, zero1, zero2;
    logic [3:0]  k1, k2, Exponent1, Exponent2;
    logic [7:0]  Mantissa1, Mantissa2;
    logic        in_ready, out_valid, busy, inf, zero, Sign;
    logic [15:0] Div_Mant_N;
    logic [11:0] Total_EO;
    logic [3:0]  E_O;
    logic [7:0]  R_O, sumR;
    logic [50:0] res;
    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;

    typedef struct {
        logic s1, s2, i1, i2, z1, z2;
        logic [3:0] k1, k2, e1, e2;
        logic [7:0] m1, m2;
        logic [50:0] exp;
    } vec_t;

    vec_t vecs[5];
    vec_t fv[4];

    posit_div_seq #(.N(8), .ES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Sign1(Sign1), .Sign2(Sign2), .k1(k1), .k2(k2),
        .Exponent1(Exponent1), .Exponent2(Exponent2),
        .Mantissa1(Mantissa1), .Mantissa2(Mantissa2),
        .inf1(inf1), .inf2(inf2), .zero1(zero1), .zero2(zero2),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .Div_Mant_N(Div_Mant_N), .Total_EO(Total_EO), .E_O(E_O),
        .R_O(R_O), .sumR(sumR), .inf(inf), .zero(zero), .Sign(Sign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    assign res = {Div_Mant_N, Total_EO, E_O, R_O, sumR, inf, zero, Sign};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v);
        Sign1 = v.s1; Sign2 = v.s2; inf1 = v.i1; inf2 = v.i2; zero1 = v.z1; zero2 = v.z2;
        k1 = v.k1; k2 = v.k2; Exponent1 = v.e1; Exponent2 = v.e2;
        Mantissa1 = v.m1; Mantissa2 = v.m2;
    endtask

    // Handshake in the current cycle (cycle 0); lat = cycle index where out_valid is seen, -1 on timeout.
    task automatic handshake_wait(output int lat);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=100", {in_ready, out_valid, busy});
        end
        total++;
        if (res !== 51'd0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", res);
        end
    endtask

    task automatic test_divide(input int idx, input string name);
        int lat;
        out_ready = 1'b1;
        set_vec(vecs[idx]);
        handshake_wait(lat);
        total++;
        if (lat !== 18) begin
            bad++; $display("FAIL %s_latency got=%0d exp=18", name, lat);
        end
        total++;
        if (res !== vecs[idx].exp) begin
            bad++; $display("FAIL %s_result got=%h exp=%h", name, res, vecs[idx].exp);
        end
        tick();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL %s_release got=%b exp=01", name, {out_valid, in_ready});
        end
    endtask

    task automatic test_special();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_vec(fv[i]);
            handshake_wait(lat);
            total++;
            if (lat !== 1) begin
                bad++; $display("FAIL special%0d_latency got=%0d exp=1", i, lat);
            end
            total++;
            if (res !== fv[i].exp) begin
                bad++; $display("FAIL special%0d_result got=%h exp=%h", i, res, fv[i].exp);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int lat;
        out_ready = 1'b0;
        set_vec(vecs[0]);
        handshake_wait(lat);
        total++;
        if (lat !== 18) begin
            bad++; $display("FAIL stall_latency got=%0d exp=18", lat);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            Mantissa1 = 8'hC3 + 8'(i);
            zero2 = in_valid;
            tick();
            total++;
            if ({res, out_valid, in_ready} !== {vecs[0].exp, 1'b1, 1'b0}) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%b%b exp=%h/10", i, res, out_valid, in_ready, vecs[0].exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL stall_accept got=%b exp=01", {out_valid, in_ready});
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL stall_single got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_abort();
        int lat;
        out_ready = 1'b1;
        set_vec(vecs[1]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL abort_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, res} !== {3'b100, 51'd0}) begin
            bad++; $display("FAIL abort_state got=%b%b%b/%h exp=100/0", in_ready, out_valid, busy, res);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL abort_noresult got=%b exp=0", out_valid);
        end
        set_vec(vecs[2]);
        handshake_wait(lat);
        total++;
        if (lat !== 18 || res !== vecs[2].exp) begin
            bad++; $display("FAIL abort_next got=%0d/%h exp=18/%h", lat, res, vecs[2].exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        int prev;
        out_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                total++;
                if (cyc_cnt - prev !== 19) begin
                    bad++; $display("FAIL b2b%0d_period got=%0d exp=19", i, cyc_cnt - prev);
                end
            end
            prev = cyc_cnt;
            set_vec(vecs[i]);
            handshake_wait(lat);
            total++;
            if (lat !== 18 || res !== vecs[i].exp) begin
                bad++; $display("FAIL b2b%0d_result got=%0d/%h exp=18/%h", i, lat, res, vecs[i].exp);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        // Fields: s1 s2 i1 i2 z1 z2 k1 k2 e1 e2 m1 m2 {Div, Total, E_O, R_O, sumR, inf, zero, Sign}
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h3, 4'h1, 8'h80, 8'h80,
                    {16'h8000, 12'h012, 4'h2, 8'h02, 8'h01, 3'b000}};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h80, 8'hC0,
                    {16'hAAAB, 12'hFFF, 4'hF, 8'h01, 8'h00, 3'b000}};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h2, 4'h0, 4'h5, 8'hFF, 8'h80,
                    {16'hFF00, 12'hFCB, 4'hB, 8'h04, 8'hFD, 3'b001}};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE, 4'hD, 4'h7, 4'h2, 8'h90, 8'hF0,
                    {16'h9999, 12'h014, 4'h4, 8'h02, 8'h01, 3'b001}};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 8'h80, 8'h80,
                    {16'h8000, 12'hFF0, 4'h0, 8'h01, 8'hFF, 3'b000}};
        fv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h2, 4'h1, 8'hA0, 8'h00,
                  {16'h0000, 12'h001, 4'h1, 8'h01, 8'h00, 3'b101}};
        fv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h2, 4'h1, 8'hA0, 8'h00,
                  {16'h0000, 12'h001, 4'h1, 8'h01, 8'h00, 3'b101}};
        fv[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h2, 4'h1, 8'h00, 8'hC0,
                  {16'h0000, 12'h001, 4'h1, 8'h01, 8'h00, 3'b010}};
        fv[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'h2, 4'h1, 8'h00, 8'h00,
                  {16'h0000, 12'h001, 4'h1, 8'h01, 8'h00, 3'b100}};
        set_vec(vecs[0]);
        test_reset();
        test_divide(0, "basic");
        test_divide(1, "sticky");
        test_divide(4, "negscale");
        test_special();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
